rbus_arb_rr: RTL and testbench



---
 rtl/rbus_arb_rr.sv | 188 ++++++++++++++++++
 tb/tb_rbus_arb_rr.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/rbus_arb_rr.sv
// rbus_arb_rr: packet-level round-robin arbiter sharing one rbus output link
// between N requesters. A grant is held for a whole packet (header length
// field + 1 words). A per-input weight allows up to that many back-to-back
// packets from one input before priority rotates.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   i_stb/i_sof     per-input word strobe / start-of-frame (header word)
//   i_data          per-input 72-bit word, input k at [72*k +: 72]
//   i_rdy, i_rdyE   per-input 2-bit ready {room, accept}, identical copies
//   o_stb/o_sof     output word strobe / start-of-frame
//   o_data          output word (zero when nothing is granted)
//   o_rdy           downstream ready: bit0 word accepted, bit1 room for 16 words
//   o_rdyE          unused
//   cfg_weight      per-input consecutive-packet quota (0 behaves as 1)
//   ff_err          sticky protocol error (sof missing / sof inside body)
module rbus_arb_rr #(
  parameter int N       = 4,
  parameter int LEN_LSB = 64,
  parameter int WMAX_W  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        i_stb,
  input  logic [N-1:0]        i_sof,
  input  logic [72*N-1:0]     i_data,
  output logic [2*N-1:0]      i_rdy,
  output logic [2*N-1:0]      i_rdyE,
  output logic                o_stb,
  output logic                o_sof,
  output logic [71:0]         o_data,
  input  logic [1:0]          o_rdy,
  input  logic [1:0]          o_rdyE,
  input  logic [WMAX_W*N-1:0] cfg_weight,
  output logic                ff_err
);

  localparam int          IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned NU = N;

  typedef enum logic [1:0] {S_IDLE, S_HEAD, S_BODY, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [N-1:0]      gnt_q, gnt_d;
  logic [IW-1:0]     gidx_q, gidx_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [3:0]        word_cnt_q, word_cnt_d;
  logic [WMAX_W-1:0] quota_cnt_q, quota_cnt_d;
  logic              ff_err_q, ff_err_d;

  logic [71:0]       data_arr [N];
  logic [WMAX_W-1:0] wt_arr [N];
  logic [N-1:0]      req;
  logic              granted, xfer, cur_sof;
  logic [71:0]       cur_data;
  logic [3:0]        hdr_len;
  logic [WMAX_W:0]   weight_eff, quota_next;
  logic              hold_prev, found;
  logic [IW-1:0]     win_idx, sel;
  int unsigned       cand;
  logic              unused_rdye;

  assign unused_rdye = ^o_rdyE;

  always_comb begin
    for (int unsigned k = 0; k < NU; k++) begin
      data_arr[k] = i_data[k*72 +: 72];
      wt_arr[k]   = cfg_weight[k*WMAX_W +: WMAX_W];
    end
  end

  assign req      = i_stb & i_sof;
  assign granted  = |gnt_q;
  assign cur_data = data_arr[gidx_q];
  assign cur_sof  = i_sof[gidx_q];
  assign hdr_len  = cur_data[LEN_LSB +: 4];
  assign xfer     = granted & i_stb[gidx_q] & o_rdy[0];

  assign o_stb  = xfer;
  assign o_sof  = granted & cur_sof;
  assign o_data = granted ? cur_data : '0;
  assign ff_err = ff_err_q;

  always_comb begin
    for (int unsigned k = 0; k < NU; k++) begin
      i_rdy[2*k +: 2] = {gnt_q[k] & o_rdy[1], gnt_q[k] & o_rdy[0]};
    end
  end
  assign i_rdyE = i_rdy;

  // gidx_q keeps the last winner after the grant drops, so quota and
  // rotation in DONE and the keep-priority test in IDLE refer to it.
  assign weight_eff = (wt_arr[gidx_q] == '0) ? (WMAX_W+1)'(1) : {1'b0, wt_arr[gidx_q]};
  assign quota_next = {1'b0, quota_cnt_q} + (WMAX_W+1)'(1);
  // A nonzero quota means the last winner finished a packet without
  // exhausting its weight, so it may continue ahead of rr_ptr.
  assign hold_prev  = (quota_cnt_q != '0) && req[gidx_q] &&
                      ({1'b0, quota_cnt_q} < weight_eff);

  // Cyclic search for the first requester at or after rr_ptr.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = 0;
    for (int unsigned i = 0; i < NU; i++) begin
      cand = (32'(rr_ptr_q) + i) % NU;
      if (!found && req[cand]) begin
        found   = 1'b1;
        win_idx = IW'(cand);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gidx_d      = gidx_q;
    rr_ptr_d    = rr_ptr_q;
    word_cnt_d  = word_cnt_q;
    quota_cnt_d = quota_cnt_q;
    ff_err_d    = ff_err_q;
    sel         = hold_prev ? gidx_q : win_idx;
    case (state_q)
      S_IDLE: begin
        if ((|req) && o_rdy[1]) begin
          gidx_d     = sel;
          gnt_d      = '0;
          gnt_d[sel] = 1'b1;
          if (sel != gidx_q) quota_cnt_d = '0;
          state_d    = S_HEAD;
        end
      end
      S_HEAD: begin
        if (xfer) begin
          if (!cur_sof) ff_err_d = 1'b1;
          word_cnt_d = hdr_len;
          if (hdr_len == 4'd0) begin
            gnt_d   = '0;
            state_d = S_DONE;
          end else begin
            state_d = S_BODY;
          end
        end
      end
      S_BODY: begin
        if (xfer) begin
          if (cur_sof) ff_err_d = 1'b1;
          word_cnt_d = word_cnt_q - 4'd1;
          if (word_cnt_q == 4'd1) begin
            gnt_d   = '0;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (quota_next >= weight_eff) begin
          rr_ptr_d    = (gidx_q == IW'(N-1)) ? '0 : IW'(gidx_q + 1'b1);
          quota_cnt_d = '0;
        end else begin
          quota_cnt_d = quota_next[WMAX_W-1:0];
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      gnt_q       <= '0;
      gidx_q      <= '0;
      rr_ptr_q    <= '0;
      word_cnt_q  <= '0;
      quota_cnt_q <= '0;
      ff_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gidx_q      <= gidx_d;
      rr_ptr_q    <= rr_ptr_d;
      word_cnt_q  <= word_cnt_d;
      quota_cnt_q <= quota_cnt_d;
      ff_err_q    <= ff_err_d;
    end
  end

endmodule

// File: tb/tb_rbus_arb_rr.sv
// Directed bench for rbus_arb_rr: per-input packet queues act as requesters,
// output words are logged with their cycle and compared to hand-derived
// expectations.
module tb_rbus_arb_rr;
  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    i_stb, i_sof;
  logic [72*N-1:0] i_data;
  logic [2*N-1:0]  i_rdy, i_rdyE;
  logic            o_stb, o_sof;
  logic [71:0]     o_data;
  logic [1:0]      o_rdy, o_rdyE;
  logic [2*N-1:0]  cfg_weight;
  logic            ff_err;

  always #5 clk = ~clk;

  rbus_arb_rr #(.N(N), .LEN_LSB(64), .WMAX_W(2)) dut (
    .clk(clk), .rst(rst), .i_stb(i_stb), .i_sof(i_sof), .i_data(i_data),
    .i_rdy(i_rdy), .i_rdyE(i_rdyE), .o_stb(o_stb), .o_sof(o_sof),
    .o_data(o_data), .o_rdy(o_rdy), .o_rdyE(o_rdyE),
    .cfg_weight(cfg_weight), .ff_err(ff_err)
  );

  logic [72:0] srcq [N][$];
  logic [72:0] outq [$];
  int          outc [$];
  logic        fflog   [0:127];
  logic [1:0]  rdy0log [0:127];
  int cyc, st_lo, st_hi, r1_from;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    i_stb  = '0;
    i_sof  = '0;
    i_data = '0;
    for (int k = 0; k < N; k++) begin
      if (srcq[k].size() > 0) begin
        i_stb[k]           = 1'b1;
        i_sof[k]           = srcq[k][0][72];
        i_data[k*72 +: 72] = srcq[k][0][71:0];
      end
    end
    o_rdy[0] = !(cyc >= st_lo && cyc <= st_hi);
    o_rdy[1] = (cyc >= r1_from);
  endtask

  task automatic run(input int n);
    logic [N-1:0] acc;
    for (int c = 0; c < n; c++) begin
      drive();
      @(negedge clk);
      if (o_stb) begin
        outq.push_back({o_sof, o_data});
        outc.push_back(cyc);
      end
      if (cyc < 128) begin
        fflog[cyc]   = ff_err;
        rdy0log[cyc] = i_rdy[1:0];
      end
      for (int k = 0; k < N; k++) acc[k] = i_stb[k] & i_rdy[2*k];
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) if (acc[k]) void'(srcq[k].pop_front());
      cyc++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int k = 0; k < N; k++) srcq[k].delete();
    outq.delete();
    outc.delete();
    st_lo   = 1000;
    st_hi   = 1000;
    r1_from = 0;
    cyc     = 0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    cyc = 0;
  endtask

  // Tag in data[63:0] = k*256 + p*16 + w; header carries length in [67:64].
  task automatic pkt(input int k, input int p, input int len, input int bad = -1);
    for (int w = 0; w <= len; w++) begin
      logic [72:0] wd;
      wd         = '0;
      wd[72]     = (w == 0) || (w == bad);
      wd[71:68]  = 4'(k);
      if (w == 0) wd[67:64] = 4'(len);
      wd[63:0]   = 64'(k*256 + p*16 + w);
      srcq[k].push_back(wd);
    end
  endtask

  initial begin
    o_rdyE     = 2'b00;
    cfg_weight = 8'b01_01_01_01;
    rst        = 1'b0;
    cyc        = 0;
    st_lo      = 1000;
    st_hi      = 1000;
    r1_from    = 0;
    pkt(0, 0, 2);
    drive();
    #12;
    chk("rst_o_stb", o_stb, 0);
    chk("rst_o_sof", o_sof, 0);
    chk("rst_o_data", o_data, 0);
    chk("rst_i_rdy", i_rdy, 0);
    chk("rst_i_rdyE", i_rdyE, 0);
    chk("rst_ff_err", ff_err, 0);

    // Round robin, weights 1, four 3-word packets
    do_reset();
    cfg_weight = 8'b01_01_01_01;
    for (int k = 0; k < N; k++) pkt(k, 0, 2);
    run(30);
    chk("rr_count", outq.size(), 12);
    for (int j = 0; j < 12; j++) begin
      chk("rr_tag", outq[j][15:0], 16'((j/3)*256 + (j%3)));
      chk("rr_sof", outq[j][72], ((j % 3) == 0) ? 1 : 0);
    end
    chk("rr_first_hdr", outc[0], 1);
    for (int p = 0; p < 3; p++) begin
      chk("rr_hdr_gap", outc[3*p+3] - outc[3*p], 5);
      chk("rr_burst", outc[3*p+2] - outc[3*p], 2);
    end
    chk("rr_ff_err", ff_err, 0);

    // Weight 2 on input 1
    do_reset();
    cfg_weight = 8'b01_01_10_01;
    pkt(1, 0, 0); pkt(1, 1, 0); pkt(2, 0, 0); pkt(2, 1, 0);
    run(20);
    chk("wt_count", outq.size(), 4);
    chk("wt_0", outq[0][15:0], 16'h100);
    chk("wt_1", outq[1][15:0], 16'h110);
    chk("wt_2", outq[2][15:0], 16'h200);
    chk("wt_3", outq[3][15:0], 16'h210);
    // rr_ptr now 3: input 3 beats input 0
    pkt(0, 2, 0); pkt(3, 2, 0);
    run(12);
    chk("wt_ptr_count", outq.size(), 6);
    chk("wt_ptr_first", outq[4][15:0], 16'h320);
    chk("wt_ptr_second", outq[5][15:0], 16'h020);

    // 16-word packet with o_rdy[0] low for cycles 4..6
    do_reset();
    cfg_weight = 8'b01_01_01_01;
    pkt(2, 0, 15);
    srcq[2].push_back({1'b0, 4'd2, 4'd0, 64'h2FF});
    st_lo = 4;
    st_hi = 6;
    run(30);
    chk("bp_count", outq.size(), 16);
    for (int j = 0; j < 16; j++) chk("bp_order", outq[j][15:0], 16'(16'h200 + j));
    chk("bp_pre_stall", outc[2], 3);
    chk("bp_post_stall", outc[3], 7);
    chk("bp_last", outc[15], 19);
    chk("bp_left", srcq[2].size(), 1);
    chk("bp_ff_err", ff_err, 0);

    // o_rdy[1] gating in IDLE
    do_reset();
    pkt(0, 0, 0);
    r1_from = 5;
    run(12);
    chk("room_rdy_c0", rdy0log[0], 0);
    chk("room_rdy_c4", rdy0log[4], 0);
    chk("room_rdy_c5", rdy0log[5], 0);
    chk("room_rdy_c6", rdy0log[6], 2'b11);
    chk("room_count", outq.size(), 1);
    chk("room_hdr_cyc", outc[0], 6);

    // sof inside body sets sticky ff_err
    do_reset();
    pkt(2, 0, 3, 2);
    pkt(2, 1, 1);
    run(30);
    chk("err_count", outq.size(), 6);
    chk("err_w1_sof", outq[1][72], 0);
    chk("err_w2_sof", outq[2][72], 1);
    chk("err_w3_tag", outq[3][15:0], 16'h203);
    chk("err_next_hdr", outq[4][15:0], 16'h210);
    chk("err_next_cyc", outc[4], 7);
    chk("err_ff_c3", fflog[3], 0);
    chk("err_ff_c4", fflog[4], 1);
    chk("err_ff_end", ff_err, 1);

    // Asynchronous reset mid-body
    do_reset();
    pkt(1, 0, 7);
    run(3);
    drive();
    #2;
    chk("mid_pre_stb", o_stb, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_stb", o_stb, 0);
    chk("mid_rst_rdy", i_rdy, 0);
    chk("mid_rst_data", o_data, 0);
    chk("mid_rst_ff", ff_err, 0);
    pkt(3, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    cyc = 0;
    outq.delete();
    outc.delete();
    run(15);
    chk("mid_count", outq.size(), 1);
    chk("mid_tag", outq[0][15:0], 16'h300);
    chk("mid_cyc", outc[0], 1);
    chk("mid_stale_left", srcq[1].size(), 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
